sdram_wr_buffer: RTL and testbench

Write-side staging buffer upstream of the SDRAM top level. It accepts single 16-bit words from a producer over a valid/ready handshake and stores them in a 512-word FIFO. It launches burst write requests (address, length, request) into the SDRAM controller's write port and streams FIFO words out on each controller acknowledge beat. The burst address auto-increments and wraps, so a producer sees a linear write stream.

---
 rtl/sdram_wr_buffer_pkg.sv | 27 ++
 rtl/sdram_wr_fifo.sv | 60 ++++++
 rtl/sdram_wr_buffer.sv | 130 +++++++++++++
 tb/tb_sdram_wr_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_wr_buffer_pkg.sv
// Shared types and sizes for the SDRAM write staging buffer.
// Holds the burst FSM encoding, the FIFO geometry and a burst-length helper.
package sdram_wr_buffer_pkg;

    localparam int unsigned FIFO_DEPTH = 512;
    localparam int unsigned PTR_W      = 9;
    localparam int unsigned CNT_W      = PTR_W + 1;
    localparam int unsigned ADDR_W     = 24;
    localparam int unsigned DATA_W     = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StData = 2'd2,
        StDone = 2'd3
    } wr_state_e;

    // A burst never exceeds what is buffered, nor the configured full-burst length.
    function automatic logic [PTR_W-1:0] burst_len(input logic [CNT_W-1:0] count,
                                                   input int unsigned      full_len);
        if (count >= CNT_W'(full_len)) begin
            return PTR_W'(full_len);
        end
        return count[PTR_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_wr_fifo.sv
// 512 x 16 synchronous show-ahead FIFO: head is the oldest word whenever count is non-zero.
// Count and full are registered; full is asserted on the same edge the count reaches the depth.
module sdram_wr_fifo
    import sdram_wr_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              full_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(FIFO_DEPTH));
        end
    end

    assign head  = mem[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;

endmodule

// File: rtl/sdram_wr_buffer.sv
// Write staging buffer: queues producer words and replays them as SDRAM burst writes.
// The burst start address advances by each burst length and wraps back to base_addr.
module sdram_wr_buffer
    import sdram_wr_buffer_pkg::*;
#(
    parameter int unsigned       BURST_LEN = 256,
    parameter logic [ADDR_W-1:0] ADDR_MAX  = 24'hFFFFFF
) (
    input  logic              clk_50m,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              addr_load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              sdram_init_done,
    input  logic              sdram_busy,
    output logic              sdram_wr_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [PTR_W-1:0]  sdwr_bytes,
    input  logic              sdram_wr_ack,
    output logic [DATA_W-1:0] sdram_wr_data,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              burst_active
);

    wr_state_e         state_q;
    logic              req_q;
    logic              active_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [PTR_W-1:0]  bytes_q;
    logic [PTR_W-1:0]  beat_q;

    logic              push;
    logic              pop;
    logic              full;
    logic [DATA_W-1:0] head;
    logic              launch;
    logic [ADDR_W:0]   ptr_sum;
    logic [ADDR_W-1:0] ptr_next;

    assign push = in_valid && !full;
    assign pop  = sdram_wr_ack && (state_q == StReq || state_q == StData);

    sdram_wr_fifo u_fifo (
        .clk     (clk_50m),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count),
        .full    (full)
    );

    assign launch = sdram_init_done && !sdram_busy &&
                    ((fifo_count >= CNT_W'(BURST_LEN)) || (flush && fifo_count != '0));

    // Overflow past ADDR_MAX restarts at base_addr: ADDR_MAX + 1 maps exactly onto base_addr.
    assign ptr_sum = {1'b0, ptr_q} + (ADDR_W + 1)'(bytes_q);
    always_comb begin
        ptr_next = ptr_sum[ADDR_W-1:0];
        if (ptr_sum > {1'b0, ADDR_MAX}) begin
            ptr_next = base_addr + ADDR_W'(ptr_sum - {1'b0, ADDR_MAX} - (ADDR_W + 1)'(1));
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            req_q    <= 1'b0;
            active_q <= 1'b0;
            addr_q   <= '0;
            ptr_q    <= '0;
            bytes_q  <= '0;
            beat_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (addr_load) begin
                        ptr_q <= base_addr;
                    end
                    if (launch) begin
                        state_q  <= StReq;
                        req_q    <= 1'b1;
                        active_q <= 1'b1;
                        addr_q   <= addr_load ? base_addr : ptr_q;
                        bytes_q  <= burst_len(fifo_count, BURST_LEN);
                    end
                end
                StReq: begin
                    if (sdram_wr_ack) begin
                        req_q  <= 1'b0;
                        beat_q <= PTR_W'(1);
                        if (bytes_q == PTR_W'(1)) begin
                            state_q  <= StDone;
                            active_q <= 1'b0;
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (sdram_wr_ack) begin
                        beat_q <= beat_q + PTR_W'(1);
                        if (beat_q + PTR_W'(1) == bytes_q) begin
                            state_q  <= StDone;
                            active_q <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    ptr_q   <= ptr_next;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready      = !full;
    assign sdram_wr_req  = req_q;
    assign sdram_wr_addr = addr_q;
    assign sdwr_bytes    = bytes_q;
    assign burst_active  = active_q;
    assign sdram_wr_data = (fifo_count != '0) ? head : '0;

endmodule

// File: tb/tb_sdram_wr_buffer.sv
// Self-checking bench for sdram_wr_buffer: a queue scoreboard tracks every accepted word
// and is compared against the FIFO count and the head word on every clock.
module tb_sdram_wr_buffer;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [23:0] base_addr;
    logic        addr_load;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        sdram_init_done;
    logic        sdram_busy;
    logic        sdram_wr_req;
    logic [23:0] sdram_wr_addr;
    logic [8:0]  sdwr_bytes;
    logic        sdram_wr_ack;
    logic [15:0] sdram_wr_data;
    logic [9:0]  fifo_count;
    logic        burst_active;

    int          checks = 0;
    int          errors = 0;
    int          pops_seen = 0;
    logic [15:0] sb_q[$];

    always #10 clk_50m = ~clk_50m;

    sdram_wr_buffer dut (
        .clk_50m         (clk_50m),
        .rst_n           (rst_n),
        .base_addr       (base_addr),
        .addr_load       (addr_load),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .flush           (flush),
        .sdram_init_done (sdram_init_done),
        .sdram_busy      (sdram_busy),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdwr_bytes      (sdwr_bytes),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_wr_data   (sdram_wr_data),
        .fifo_count      (fifo_count),
        .burst_active    (burst_active)
    );

    // Scoreboard: sampled mid-cycle, i.e. just before the edge that will act on these inputs.
    always @(negedge clk_50m) begin
        if (rst_n) begin
            checks++;
            if (fifo_count !== 10'(sb_q.size())) begin
                errors++;
                $display("FAIL sb_count: got %0d expected %0d", fifo_count, sb_q.size());
            end
            if (sb_q.size() != 0) begin
                checks++;
                if (sdram_wr_data !== sb_q[0]) begin
                    errors++;
                    $display("FAIL sb_data: got %h expected %h", sdram_wr_data, sb_q[0]);
                end
                if (sdram_wr_ack && burst_active) begin
                    void'(sb_q.pop_front());
                    pops_seen++;
                end
            end
            if (in_valid && in_ready) sb_q.push_back(in_data);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic push_words(input int n, input logic [15:0] start, output int sent);
        int guard = 0;
        bit acc;
        sent = 0;
        while (sent < n && guard < 3000) begin
            in_valid = 1'b1;
            in_data  = start + 16'(sent);
            acc      = in_ready;
            @(posedge clk_50m); #1;
            if (acc) sent++;
            guard++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_req(input int budget, output bit ok);
        int i = 0;
        ok = sdram_wr_req;
        while (!ok && i < budget) begin
            @(posedge clk_50m); #1;
            ok = sdram_wr_req;
            i++;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int i = 0;
        ok = !burst_active;
        while (!ok && i < budget) begin
            @(posedge clk_50m); #1;
            ok = !burst_active;
            i++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        base_addr = '0; addr_load = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
        sdram_init_done = 1'b1; sdram_busy = 1'b0; sdram_wr_ack = 1'b0;
        #35 rst_n = 1'b1;
        @(posedge clk_50m); #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        checks++; if (sdram_wr_req !== 1'b0) begin errors++;
            $display("FAIL rst_req: got %b expected 0", sdram_wr_req); end
        checks++; if (sdram_wr_addr !== 24'h0) begin errors++;
            $display("FAIL rst_addr: got %h expected 0", sdram_wr_addr); end
        checks++; if (sdwr_bytes !== 9'd0) begin errors++;
            $display("FAIL rst_bytes: got %0d expected 0", sdwr_bytes); end
        checks++; if (sdram_wr_data !== 16'h0) begin errors++;
            $display("FAIL rst_data: got %h expected 0", sdram_wr_data); end
        checks++; if (fifo_count !== 10'd0) begin errors++;
            $display("FAIL rst_count: got %0d expected 0", fifo_count); end
        checks++; if (burst_active !== 1'b0) begin errors++;
            $display("FAIL rst_active: got %b expected 0", burst_active); end
    endtask

    task automatic test_full_burst();
        int sent, p0;
        bit ok;
        sdram_wr_ack = 1'b1;
        p0 = pops_seen;
        push_words(256, 16'h0000, sent);
        wait_req(10, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fb_req: got 0 expected 1"); end
        checks++; if (sdram_wr_addr !== 24'd0) begin errors++;
            $display("FAIL fb_addr: got %h expected 0", sdram_wr_addr); end
        checks++; if (sdwr_bytes !== 9'd256) begin errors++;
            $display("FAIL fb_bytes: got %0d expected 256", sdwr_bytes); end
        checks++; if (burst_active !== 1'b1) begin errors++;
            $display("FAIL fb_active: got %b expected 1", burst_active); end
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL fb_idle: got busy expected idle"); end
        checks++; if (pops_seen - p0 != 256) begin errors++;
            $display("FAIL fb_beats: got %0d expected 256", pops_seen - p0); end
        checks++; if (fifo_count !== 10'd0) begin errors++;
            $display("FAIL fb_count: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_flush();
        int sent;
        bit ok;
        sdram_wr_ack = 1'b1;
        push_words(5, 16'h1000, sent);
        sdram_busy = 1'b1;
        flush = 1'b1;
        repeat (4) @(posedge clk_50m); #1;
        checks++; if (sdram_wr_req !== 1'b0) begin errors++;
            $display("FAIL fl_busy_block: got %b expected 0", sdram_wr_req); end
        sdram_busy = 1'b0;
        wait_req(5, ok);
        flush = 1'b0;
        checks++; if (!ok) begin errors++; $display("FAIL fl_req: got 0 expected 1"); end
        checks++; if (sdram_wr_addr !== 24'd256) begin errors++;
            $display("FAIL fl_addr: got %h expected 100", sdram_wr_addr); end
        checks++; if (sdwr_bytes !== 9'd5) begin errors++;
            $display("FAIL fl_bytes: got %0d expected 5", sdwr_bytes); end
        wait_idle(50, ok);
        // Single-word burst, also blocked while the controller is not initialised.
        push_words(1, 16'h2000, sent);
        sdram_init_done = 1'b0;
        flush = 1'b1;
        repeat (3) @(posedge clk_50m); #1;
        checks++; if (sdram_wr_req !== 1'b0) begin errors++;
            $display("FAIL fl_init_block: got %b expected 0", sdram_wr_req); end
        sdram_init_done = 1'b1;
        wait_req(5, ok);
        flush = 1'b0;
        checks++; if (sdram_wr_addr !== 24'd261) begin errors++;
            $display("FAIL fl1_addr: got %h expected 105", sdram_wr_addr); end
        checks++; if (sdwr_bytes !== 9'd1) begin errors++;
            $display("FAIL fl1_bytes: got %0d expected 1", sdwr_bytes); end
        wait_idle(20, ok);
        @(posedge clk_50m); #1;
        checks++; if (fifo_count !== 10'd0 || burst_active !== 1'b0) begin errors++;
            $display("FAIL fl1_end: got count %0d active %b expected 0 0", fifo_count,
                     burst_active); end
    endtask

    task automatic test_full_fifo();
        int sent;
        bit ok;
        sdram_wr_ack = 1'b0;
        push_words(512, 16'h4000, sent);
        checks++; if (sent != 512) begin errors++;
            $display("FAIL ff_sent: got %0d expected 512", sent); end
        checks++; if (in_ready !== 1'b0 || fifo_count !== 10'd512) begin errors++;
            $display("FAIL ff_full: got ready %b count %0d expected 0 512", in_ready,
                     fifo_count); end
        in_valid = 1'b1; in_data = 16'hDEAD;
        @(posedge clk_50m); #1;
        in_valid = 1'b0;
        checks++; if (fifo_count !== 10'd512) begin errors++;
            $display("FAIL ff_nopush: got %0d expected 512", fifo_count); end
        checks++; if (sdram_wr_req !== 1'b1 || sdram_wr_addr !== 24'd262 ||
                      sdwr_bytes !== 9'd256) begin errors++;
            $display("FAIL ff_req: got %b %h %0d expected 1 000106 256", sdram_wr_req,
                     sdram_wr_addr, sdwr_bytes); end
        sdram_wr_ack = 1'b1;
        @(posedge clk_50m); #1;
        checks++; if (in_ready !== 1'b1 || fifo_count !== 10'd511) begin errors++;
            $display("FAIL ff_release: got ready %b count %0d expected 1 511", in_ready,
                     fifo_count); end
        wait_idle(400, ok);
        wait_req(10, ok);
        checks++; if (!ok || sdram_wr_addr !== 24'd518) begin errors++;
            $display("FAIL ff_req2: got %b %h expected 1 000206", ok, sdram_wr_addr); end
        wait_idle(400, ok);
        checks++; if (fifo_count !== 10'd0) begin errors++;
            $display("FAIL ff_drain: got %0d expected 0", fifo_count); end
    endtask

    task automatic test_ack_toggle();
        int sent, p0, i;
        bit ok;
        logic a;
        sdram_wr_ack = 1'b0;
        p0 = pops_seen;
        push_words(256, 16'h8000, sent);
        wait_req(10, ok);
        checks++; if (!ok || sdram_wr_addr !== 24'd774) begin errors++;
            $display("FAIL at_req: got %b %h expected 1 000306", ok, sdram_wr_addr); end
        a = 1'b1;
        i = 0;
        while (burst_active && i < 1200) begin
            sdram_wr_ack = a;
            @(posedge clk_50m); #1;
            a = ~a;
            i++;
        end
        sdram_wr_ack = 1'b0;
        checks++; if (pops_seen - p0 != 256) begin errors++;
            $display("FAIL at_beats: got %0d expected 256", pops_seen - p0); end
        checks++; if (fifo_count !== 10'd0 || burst_active !== 1'b0) begin errors++;
            $display("FAIL at_end: got count %0d active %b expected 0 0", fifo_count,
                     burst_active); end
    endtask

    task automatic test_wrap();
        int sent;
        bit ok;
        sdram_wr_ack = 1'b1;
        @(posedge clk_50m); #1;
        base_addr = 24'hFFFF80;
        addr_load = 1'b1;
        @(posedge clk_50m); #1;
        addr_load = 1'b0;
        push_words(256, 16'hA000, sent);
        wait_req(10, ok);
        checks++; if (!ok || sdram_wr_addr !== 24'hFFFF80) begin errors++;
            $display("FAIL wr_addr1: got %b %h expected 1 ffff80", ok, sdram_wr_addr); end
        wait_idle(400, ok);
        push_words(256, 16'hB000, sent);
        wait_req(10, ok);
        // FFFF80 + 256 overshoots FFFFFF by 0x81, so the pointer lands on base + 0x80.
        checks++; if (!ok || sdram_wr_addr !== 24'h000000 || sdwr_bytes !== 9'd256) begin
            errors++;
            $display("FAIL wr_addr2: got %b %h %0d expected 1 000000 256", ok, sdram_wr_addr,
                     sdwr_bytes); end
        wait_idle(400, ok);
    endtask

    task automatic test_reset_mid();
        int sent, p0, i;
        bit ok, seen_req;
        sdram_wr_ack = 1'b1;
        p0 = pops_seen;
        push_words(256, 16'hC000, sent);
        i = 0;
        while (pops_seen - p0 < 100 && i < 400) begin
            @(posedge clk_50m); #1;
            i++;
        end
        #4 rst_n = 1'b0;
        #1;
        checks++; if (sdram_wr_req !== 1'b0 || burst_active !== 1'b0 ||
                      fifo_count !== 10'd0) begin errors++;
            $display("FAIL rm_abort: got req %b active %b count %0d expected 0 0 0",
                     sdram_wr_req, burst_active, fifo_count); end
        sb_q.delete();
        @(posedge clk_50m); #1;
        rst_n = 1'b1;
        seen_req = 1'b0;
        repeat (20) begin
            @(posedge clk_50m); #1;
            if (sdram_wr_req) seen_req = 1'b1;
        end
        checks++; if (seen_req) begin errors++;
            $display("FAIL rm_no_launch: got 1 expected 0"); end
        push_words(3, 16'hE000, sent);
        flush = 1'b1;
        wait_req(5, ok);
        flush = 1'b0;
        checks++; if (!ok || sdram_wr_addr !== 24'd0 || sdwr_bytes !== 9'd3) begin errors++;
            $display("FAIL rm_relaunch: got %b %h %0d expected 1 000000 3", ok, sdram_wr_addr,
                     sdwr_bytes); end
        wait_idle(20, ok);
        checks++; if (fifo_count !== 10'd0) begin errors++;
            $display("FAIL rm_end: got %0d expected 0", fifo_count); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_flush();
        test_full_fifo();
        test_ack_toggle();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
